// File: rtl/exu_alu_pipe.sv
// exu_alu_pipe: registered ALU execute stage for the EXU.
// Operands are resolved and the result is computed in a single cycle. The
// result is held in a main output register that is backed by a one-entry
// skid register. This gives a fully registered valid/ready boundary toward
// write-back and commit, while still sustaining one result per cycle.
module exu_alu_pipe #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_i_flush,
  input  logic            alu_i_valid,
  output logic            alu_i_ready,
  input  logic [XLEN-1:0] alu_i_rs1,
  input  logic [XLEN-1:0] alu_i_rs2,
  input  logic [XLEN-1:0] alu_i_imm,
  input  logic [XLEN-1:0] alu_i_pc,
  input  logic [3:0]      alu_i_op,
  input  logic            alu_i_op1pc,
  input  logic            alu_i_op2imm,
  input  logic            alu_i_nop,
  input  logic            alu_i_ebreak,
  input  logic [4:0]      alu_i_rdidx,
  output logic            alu_o_valid,
  input  logic            alu_o_ready,
  output logic [XLEN-1:0] alu_o_wbck_wdat,
  output logic            alu_o_wbck_en,
  output logic [4:0]      alu_o_rdidx,
  output logic            alu_o_cmt_ebreak
);

  // Buffer occupancy: ST_ONE means the main register is full; ST_TWO means
  // the skid register is full as well.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic            vld_q,     vld_d;
  logic            rdy_q,     rdy_d;
  logic [XLEN-1:0] wdat_q,    wdat_d;
  logic            wen_q,     wen_d;
  logic [4:0]      rd_q,      rd_d;
  logic            ebk_q,     ebk_d;
  logic [XLEN-1:0] sk_wdat_q, sk_wdat_d;
  logic            sk_wen_q,  sk_wen_d;
  logic [4:0]      sk_rd_q,   sk_rd_d;
  logic            sk_ebk_q,  sk_ebk_d;

  logic [XLEN-1:0] op1_s, op2_s, res_s, new_wdat_s;
  logic [SHW-1:0]  shamt_s;
  logic            new_wen_s;
  logic            in_fire_s, out_fire_s;

  // Operand selection and result computation for the incoming request.
  always_comb begin
    op1_s   = alu_i_op1pc  ? alu_i_pc  : alu_i_rs1;
    op2_s   = alu_i_op2imm ? alu_i_imm : alu_i_rs2;
    shamt_s = op2_s[SHW-1:0];
    case (alu_i_op)
      4'd0:    res_s = op1_s + op2_s;
      4'd1:    res_s = op1_s - op2_s;
      4'd2:    res_s = op1_s ^ op2_s;
      4'd3:    res_s = op1_s | op2_s;
      4'd4:    res_s = op1_s & op2_s;
      4'd5:    res_s = op1_s << shamt_s;
      4'd6:    res_s = op1_s >> shamt_s;
      4'd7:    res_s = $unsigned($signed(op1_s) >>> shamt_s);
      4'd8:    res_s = {{(XLEN-1){1'b0}}, ($signed(op1_s) < $signed(op2_s))};
      4'd9:    res_s = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
      4'd10:   res_s = op2_s;
      default: res_s = op1_s + op2_s;
    endcase
    if (alu_i_nop || alu_i_ebreak) begin
      new_wdat_s = {XLEN{1'b0}};
    end else begin
      new_wdat_s = res_s;
    end
    new_wen_s = ~alu_i_nop & ~alu_i_ebreak & (alu_i_rdidx != 5'd0);
  end

  // Next-state and buffer steering for the main/skid pair.
  always_comb begin
    state_d   = state_q;
    wdat_d    = wdat_q;
    wen_d     = wen_q;
    rd_d      = rd_q;
    ebk_d     = ebk_q;
    sk_wdat_d = sk_wdat_q;
    sk_wen_d  = sk_wen_q;
    sk_rd_d   = sk_rd_q;
    sk_ebk_d  = sk_ebk_q;
    in_fire_s  = alu_i_valid & rdy_q;
    out_fire_s = vld_q & alu_o_ready;
    if (alu_i_flush) begin
      // Flush drops both entries and any request presented this cycle.
      state_d   = ST_EMPTY;
      wdat_d    = {XLEN{1'b0}};
      wen_d     = 1'b0;
      rd_d      = 5'd0;
      ebk_d     = 1'b0;
      sk_wdat_d = {XLEN{1'b0}};
      sk_wen_d  = 1'b0;
      sk_rd_d   = 5'd0;
      sk_ebk_d  = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_ONE;
            wdat_d  = new_wdat_s;
            wen_d   = new_wen_s;
            rd_d    = alu_i_rdidx;
            ebk_d   = alu_i_ebreak;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            // Main drains and refills in the same cycle.
            state_d = ST_ONE;
            wdat_d  = new_wdat_s;
            wen_d   = new_wen_s;
            rd_d    = alu_i_rdidx;
            ebk_d   = alu_i_ebreak;
          end else if (in_fire_s) begin
            // Main is stalled, so the new entry parks in the skid register.
            state_d   = ST_TWO;
            sk_wdat_d = new_wdat_s;
            sk_wen_d  = new_wen_s;
            sk_rd_d   = alu_i_rdidx;
            sk_ebk_d  = alu_i_ebreak;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_d = ST_ONE;
            wdat_d  = sk_wdat_q;
            wen_d   = sk_wen_q;
            rd_d    = sk_rd_q;
            ebk_d   = sk_ebk_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
    vld_d = (state_d != ST_EMPTY);
    rdy_d = (state_d != ST_TWO);
  end

  // State and data registers; reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      vld_q     <= 1'b0;
      rdy_q     <= 1'b1;
      wdat_q    <= {XLEN{1'b0}};
      wen_q     <= 1'b0;
      rd_q      <= 5'd0;
      ebk_q     <= 1'b0;
      sk_wdat_q <= {XLEN{1'b0}};
      sk_wen_q  <= 1'b0;
      sk_rd_q   <= 5'd0;
      sk_ebk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
      wdat_q    <= wdat_d;
      wen_q     <= wen_d;
      rd_q      <= rd_d;
      ebk_q     <= ebk_d;
      sk_wdat_q <= sk_wdat_d;
      sk_wen_q  <= sk_wen_d;
      sk_rd_q   <= sk_rd_d;
      sk_ebk_q  <= sk_ebk_d;
    end
  end

  assign alu_i_ready      = rdy_q;
  assign alu_o_valid      = vld_q;
  assign alu_o_wbck_wdat  = wdat_q;
  assign alu_o_wbck_en    = wen_q;
  assign alu_o_rdidx      = rd_q;
  assign alu_o_cmt_ebreak = ebk_q;

endmodule

// File: doc/exu_alu_pipe.md
# exu_alu_pipe

Registered ALU execute stage for the EXU, with a parametrised datapath width. It resolves operands, computes the result, and holds it in an output register backed by a one-entry skid buffer. This gives a registered valid/ready boundary toward write-back and commit, with full throughput and no combinational path from alu_o_ready to alu_i_ready. It sits between the dispatch/decode handshake and the write-back arbiter, where the combinational regular-ALU path is replaced by this pipelined stage.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports (clock/reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_i_flush  in  1  synchronous pipeline flush.
- alu_i_valid  in  1  request valid.
- alu_i_ready  out  1  request ready (registered).
- alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc  in  XLEN each  operands.
- alu_i_op  in  4  operation code: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 LUI; 11–15 reserved, treated as ADD.
- alu_i_op1pc  in  1  op1 = pc, else rs1.
- alu_i_op2imm  in  1  op2 = imm, else rs2.
- alu_i_nop  in  1  no write-back.
- alu_i_ebreak  in  1  ebreak marker.
- alu_i_rdidx  in  5  destination register index.
- alu_o_valid  out  1  result valid.
- alu_o_ready  in  1  result accepted.
- alu_o_wbck_wdat  out  XLEN  result.
- alu_o_wbck_en  out  1  write-back enable.
- alu_o_rdidx  out  5  destination register index.
- alu_o_cmt_ebreak  out  1  ebreak to commit.

## Operation
Operand selection:
- op1 = op1pc ? pc : rs1.
- op2 = op2imm ? imm : rs2.

Result computation:
- ADD/SUB are modulo 2^XLEN.
- Shifts use op2[SHW-1:0]; SRA replicates op1[XLEN-1].
- SLT is a signed compare and SLTU unsigned; both produce zero-extended 0/1.
- LUI passes op2.
- nop or ebreak forces the result to 0.
- wbck_en = ~nop & ~ebreak & (rdidx != 0).

Handshake and buffering:
- A transfer occurs on alu_i_valid & alu_i_ready. The computed entry {wdat, wbck_en, rdidx, ebreak} is captured.
- Two storage entries: the main register (drives the outputs) and the skid register.
- State machine, derived from two valid bits:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: both full.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + out-accept → ONE (new entry replaces main).
  - ONE + accept, no out-accept → TWO (new entry to skid).
  - ONE + out-accept only → EMPTY.
  - TWO + out-accept → ONE (skid moves to main).
  - TWO never accepts.
- alu_i_ready = ~skid_valid, registered. Equivalently, the state next cycle is not TWO.
- Order is strictly FIFO.
- Flush: any state → EMPTY. Requests presented in the flush cycle are dropped.

## Timing
- Latency: an entry accepted in cycle N is visible on alu_o_* in cycle N+1.
- Throughput: 1 per cycle while alu_o_ready stays high.
- alu_o_* values are stable while alu_o_valid & ~alu_o_ready.
- alu_i_ready falls in the cycle after the skid fills. It rises in the cycle after the skid drains.
- rst (sync, highest priority), and flush (same effect, next edge):
  - alu_o_valid = 0, wdat = 0, wbck_en = 0, rdidx = 0, cmt_ebreak = 0.
  - Skid cleared; alu_i_ready = 1 after the edge.
- Reset or flush mid-stall discards both entries. No output handshake completes in that cycle.
- When alu_o_ready is high in TWO, an input presented in that cycle is not accepted (ready = 0).

## Test plan
- Reset: assert rst 2 cycles with alu_i_valid = 1 → alu_o_valid = 0 and outputs 0 throughout; alu_i_ready = 1 after release.
- Arithmetic, XLEN = 32:
  - ADD 0xFFFFFFFF + 1 → 0x0.
  - SUB 0 − 1 → 0xFFFFFFFF.
  - SRA 0x80000000 by 0x24 (amount 4) → 0xF8000000.
  - SLT −1 < 1 → 1; SLTU 0xFFFFFFFF < 1 → 0.
  - Each result appears exactly 1 cycle after accept.
- Back-to-back stream of 8 ADDs with alu_o_ready = 1 → 8 results in 8 consecutive cycles, in order.
- Backpressure:
  - Hold alu_o_ready = 0 and send A, B → alu_o_* shows A stably; alu_i_ready = 0 from the cycle after B.
  - Release → A, then B, in consecutive cycles; ready returns 1 the cycle after B moves to main.
- Flags:
  - nop with rdidx = 5 → wbck_en = 0, wdat = 0.
  - ADD with rdidx = 0 → wbck_en = 0.
  - ebreak → cmt_ebreak = 1, wdat = 0.
  - op1pc with pc = 0x80000000 and ADD imm = 4 → 0x80000004.
- Flush in TWO → next cycle alu_o_valid = 0 and alu_i_ready = 1; neither buffered entry is ever emitted.
